// File: rtl/mem_pkg.sv
// Shared types for the DataMemory front-end: address/data widths,
// memory latency and the in-flight load record.
package mem_pkg;

  localparam int MEM_ADDR_W   = 15;
  localparam int MEM_DATA_W   = 16;
  localparam int MEM_LATENCY  = 100;
  // Widest load tag the pipe record can carry; narrower tags are zero-extended.
  localparam int LD_TAG_MAX_W = 16;

  typedef logic [MEM_ADDR_W-1:0] mem_addr_t;
  typedef logic [MEM_DATA_W-1:0] mem_data_t;

  typedef struct packed {
    logic                    valid;
    logic [LD_TAG_MAX_W-1:0] tag;
    mem_addr_t               addr;
  } ld_entry_t;

endpackage

// File: rtl/load_store_tracker_if.sv
// Signal bundle between the core, the tracker and DataMemory.
// master = core/memory side, slave = load_store_tracker.
interface load_store_tracker_if
  import mem_pkg::*;
#(
  parameter int TAG_W   = 6,
  parameter int LATENCY = MEM_LATENCY
);

  logic                           ld_valid;
  logic                           ld_ready;
  mem_addr_t                      ld_addr;
  logic [TAG_W-1:0]               ld_tag;
  logic                           st_valid;
  logic                           st_ready;
  mem_addr_t                      st_addr;
  mem_data_t                      st_data;
  logic                           flush;
  mem_addr_t                      mem_raddr;
  mem_data_t                      mem_rdata;
  logic                           mem_wen;
  mem_addr_t                      mem_waddr;
  mem_data_t                      mem_wdata;
  logic                           cpl_valid;
  logic [TAG_W-1:0]               cpl_tag;
  mem_data_t                      cpl_data;
  logic [$clog2(LATENCY+1)-1:0]   inflight;
  logic                           busy;

  modport master (
    output ld_valid, ld_addr, ld_tag, st_valid, st_addr, st_data, flush, mem_rdata,
    input  ld_ready, st_ready, mem_raddr, mem_wen, mem_waddr, mem_wdata,
           cpl_valid, cpl_tag, cpl_data, inflight, busy
  );

  modport slave (
    input  ld_valid, ld_addr, ld_tag, st_valid, st_addr, st_data, flush, mem_rdata,
    output ld_ready, st_ready, mem_raddr, mem_wen, mem_waddr, mem_wdata,
           cpl_valid, cpl_tag, cpl_data, inflight, busy
  );

endinterface

// File: rtl/load_tag_pipe.sv
// LATENCY-deep shift of in-flight load records, aligned with the memory
// read latency so the tail entry lines up with the returning read data.
module load_tag_pipe
  import mem_pkg::*;
#(
  parameter int LATENCY = MEM_LATENCY
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  ld_entry_t          in_entry,
  input  mem_addr_t          cmp_addr,
  output ld_entry_t          tail,
  output logic [LATENCY-2:0] addr_match
);

  genvar gi;
  for (gi = 0; gi < LATENCY; gi++) begin : g_stage
    ld_entry_t entry_next;
    ld_entry_t entry_reg;

    if (gi == 0) begin : g_head
      assign entry_next = in_entry;
    end else begin : g_body
      assign entry_next = g_stage[gi-1].entry_reg;
    end

    // Flush kills validity only; payload keeps shifting harmlessly.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        entry_reg <= '0;
      end else begin
        entry_reg <= '{valid: entry_next.valid & ~flush,
                       tag:   entry_next.tag,
                       addr:  entry_next.addr};
      end
    end

    // The tail stage is reading memory this cycle, so it never blocks a store.
    if (gi < LATENCY - 1) begin : g_match
      assign addr_match[gi] = entry_reg.valid && (entry_reg.addr == cmp_addr);
    end
  end

  assign tail = g_stage[LATENCY-1].entry_reg;

endmodule

// File: rtl/load_store_tracker.sv
// Load/store front-end for the fixed-latency DataMemory: issues reads,
// returns tagged completions, holds back stores that would clobber older loads.
module load_store_tracker
  import mem_pkg::*;
#(
  parameter int LATENCY = MEM_LATENCY,
  parameter int TAG_W   = 6
) (
  input logic                 clk,
  input logic                 reset,
  load_store_tracker_if.slave bus
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  logic               ld_accept;
  ld_entry_t          ld_entry;
  ld_entry_t          tail;
  logic [LATENCY-2:0] addr_match;
  logic               st_hazard;
  logic [CNT_W-1:0]   inflight_reg;
  logic [CNT_W-1:0]   inflight_next;
  logic               tail_unused;

  assign ld_accept     = bus.ld_valid & ~bus.flush;
  assign bus.ld_ready  = ~bus.flush;
  assign bus.mem_raddr = bus.ld_addr;

  assign ld_entry = '{valid: ld_accept,
                      tag:   LD_TAG_MAX_W'(bus.ld_tag),
                      addr:  bus.ld_addr};

  load_tag_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk        (clk),
    .reset      (reset),
    .flush      (bus.flush),
    .in_entry   (ld_entry),
    .cmp_addr   (bus.st_addr),
    .tail       (tail),
    .addr_match (addr_match)
  );

  // A load accepted this very cycle is older than the store and must read first.
  assign st_hazard     = (|addr_match) | (ld_accept && (bus.ld_addr == bus.st_addr));
  assign bus.st_ready  = ~st_hazard;
  assign bus.mem_wen   = bus.st_valid & ~st_hazard;
  assign bus.mem_waddr = bus.st_addr;
  assign bus.mem_wdata = bus.st_data;

  assign bus.cpl_valid = tail.valid;
  assign bus.cpl_tag   = tail.tag[TAG_W-1:0];
  assign bus.cpl_data  = bus.mem_rdata;
  assign tail_unused   = ^tail;

  always_comb begin
    inflight_next = inflight_reg;
    if (bus.flush) begin
      inflight_next = '0;
    end else if (ld_accept && !tail.valid) begin
      inflight_next = inflight_reg + CNT_W'(1);
    end else if (!ld_accept && tail.valid) begin
      inflight_next = inflight_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_reg <= '0;
    end else begin
      inflight_reg <= inflight_next;
    end
  end

  assign bus.inflight = inflight_reg;
  assign bus.busy     = (inflight_reg != '0);

endmodule
